// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for the saturating up/down counter.
// Paces steps by a prescaler and counts completed round trips.
module counter_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [PRESC_W-1:0] step_div,
  input  logic [3:0]         trips,
  output logic               cnt_set,
  output logic [WIDTH-1:0]   cnt_set_val,
  output logic               cnt_en,
  output logic               cnt_up,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               cfg_err,
  output logic [3:0]         trip_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_UP   = 3'd2;
  localparam logic [2:0] S_DOWN = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [WIDTH-1:0]   W_ONE = 1;
  localparam logic [PRESC_W-1:0] P_ONE = 1;
  localparam logic [3:0]         T_ONE = 4'd1;

  logic [2:0]         state_q, state_d;
  logic [WIDTH-1:0]   pos_q, pos_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [WIDTH-1:0]   lo_q, hi_q;
  logic [PRESC_W-1:0] div_q;
  logic [3:0]         trips_q;
  logic               ld;

  logic               set_d, en_d, up_d;
  logic               done_d, abt_d, err_d;
  logic [WIDTH-1:0]   sval_d;
  logic [3:0]         trip_d;

  logic               tick;
  logic [WIDTH-1:0]   pos_inc, pos_dec;
  logic [3:0]         trip_inc;

  assign tick     = (presc_q == div_q);
  assign pos_inc  = pos_q + W_ONE;
  assign pos_dec  = pos_q - W_ONE;
  assign trip_inc = trip_cnt + T_ONE;

  // Next-state and next-output decode; abort overrides any sweep step.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    ld      = 1'b0;
    set_d   = 1'b0;
    sval_d  = cnt_set_val;
    en_d    = 1'b0;
    up_d    = 1'b0;
    done_d  = 1'b0;
    abt_d   = 1'b0;
    err_d   = 1'b0;
    trip_d  = trip_cnt;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          if (lo < hi) begin
            ld      = 1'b1;
            state_d = S_LOAD;
            trip_d  = 4'd0;
            set_d   = 1'b1;
            sval_d  = lo;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        state_d = S_UP;
        pos_d   = lo_q;
        presc_d = '0;
        up_d    = 1'b1;
      end
      S_UP: begin
        up_d = 1'b1;
        if (tick) begin
          en_d    = 1'b1;
          pos_d   = pos_inc;
          presc_d = '0;
          if (pos_inc == hi_q) state_d = S_DOWN;
        end else begin
          presc_d = presc_q + P_ONE;
        end
      end
      S_DOWN: begin
        if (tick) begin
          en_d    = 1'b1;
          pos_d   = pos_dec;
          presc_d = '0;
          if (pos_dec == lo_q) begin
            trip_d = trip_inc;
            if (trips_q != 4'd0 && trip_inc == trips_q)
              state_d = S_FIN;
            else
              state_d = S_UP;
          end
        end else begin
          presc_d = presc_q + P_ONE;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      pos_d   = pos_q;
      presc_d = presc_q;
      en_d    = 1'b0;
      up_d    = 1'b0;
      done_d  = 1'b0;
      trip_d  = trip_cnt;
      abt_d   = 1'b1;
    end
  end

  // State, position, prescaler and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pos_q       <= '0;
      presc_q     <= '0;
      cnt_set     <= 1'b0;
      cnt_set_val <= '0;
      cnt_en      <= 1'b0;
      cnt_up      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      cfg_err     <= 1'b0;
      trip_cnt    <= 4'd0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      presc_q     <= presc_d;
      cnt_set     <= set_d;
      cnt_set_val <= sval_d;
      cnt_en      <= en_d;
      cnt_up      <= up_d;
      busy        <= (state_d != S_IDLE);
      done        <= done_d;
      aborted     <= abt_d;
      cfg_err     <= err_d;
      trip_cnt    <= trip_d;
    end
  end

  // Sweep configuration captured on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q    <= '0;
      hi_q    <= '0;
      div_q   <= '0;
      trips_q <= 4'd0;
    end else if (ld) begin
      lo_q    <= lo;
      hi_q    <= hi;
      div_q   <= step_div;
      trips_q <= trips;
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: timeline model of each sweep,
// checked every cycle, plus literal pins on key cycles.
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] lo = '0;
  logic [3:0] hi = '0;
  logic [7:0] step_div = '0;
  logic [3:0] trips = '0;
  logic       cnt_set, cnt_en, cnt_up;
  logic [3:0] cnt_set_val;
  logic       busy, done, aborted, cfg_err;
  logic [3:0] trip_cnt;

  counter_sweep_ctrl #(.WIDTH(4), .PRESC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .lo(lo), .hi(hi), .step_div(step_div), .trips(trips),
    .cnt_set(cnt_set), .cnt_set_val(cnt_set_val),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .busy(busy),
    .done(done), .aborted(aborted), .cfg_err(cfg_err),
    .trip_cnt(trip_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       set;
    logic [3:0] sv;
    logic       en;
    logic       up;
    logic       busy;
    logic       done;
    logic       abt;
    logic       cerr;
    logic [3:0] trip;
  } exp_t;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  int m_kind = 0;
  int m_id = 0;
  int m_s = -1000;
  int m_lo, m_hi, m_sd, m_trips;
  int m_ta = -1;
  logic [3:0] m_trip_prev = '0;

  logic [3:0]  cval;
  logic [31:0] en_mask;

  always @(posedge clk) cyc <= cyc + 1;

  // Counter the sequencer would drive.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cval <= '0;
    else if (cnt_set) cval <= cnt_set_val;
    else if (cnt_en) cval <= cnt_up ? cval + 4'd1 : cval - 4'd1;
  end

  // Expected outputs t cycles after the start was sampled.
  function automatic exp_t model(int t);
    exp_t e;
    int L, P, first, N, done_t, stop, last, m, k;
    bit ab;
    e = '0;
    e.trip = m_trip_prev;
    if (m_kind == 2) begin
      e.cerr = (t == 1);
    end else if (m_kind == 1 && t >= 1) begin
      L = m_hi - m_lo;
      P = m_sd + 1;
      first = 3 + m_sd;
      if (m_trips == 0) begin
        N = 1 << 30;
        done_t = 1 << 30;
      end else begin
        N = 2 * L * m_trips;
        done_t = first + (N - 1) * P + 1;
      end
      ab = (m_ta >= 1) && (m_ta + 1 <= done_t);
      stop = ab ? m_ta + 1 : done_t;
      last = (t < stop - 1) ? t : stop - 1;
      m = (last < first) ? 0 : (last - first) / P + 1;
      if (m > N) m = N;
      e.trip = 4'((m / (2 * L)) % 16);
      e.busy = (t < stop);
      e.set = (t == 1);
      e.sv = 4'(m_lo);
      if (t >= first && t < stop && (t - first) % P == 0) begin
        k = (t - first) / P;
        e.en = 1'b1;
        e.up = ((k % (2 * L)) < L);
      end
      e.done = !ab && (t == done_t);
      e.abt = ab && (t == m_ta + 1);
    end
    return e;
  endfunction

  task automatic chk(string name, int t, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got %0d expected %0d",
               name, t, act, exp);
    end
  endtask

  // Per-cycle compare against the model, plus literal pins.
  always @(negedge clk) begin
    int t;
    exp_t e;
    t = cyc - m_s;
    e = model(t);
    chk("cnt_set", t, int'(cnt_set), int'(e.set));
    if (e.set) chk("cnt_set_val", t, int'(cnt_set_val), int'(e.sv));
    chk("cnt_en", t, int'(cnt_en), int'(e.en));
    if (e.en) chk("cnt_up", t, int'(cnt_up), int'(e.up));
    chk("busy", t, int'(busy), int'(e.busy));
    chk("done", t, int'(done), int'(e.done));
    chk("aborted", t, int'(aborted), int'(e.abt));
    chk("cfg_err", t, int'(cfg_err), int'(e.cerr));
    chk("trip_cnt", t, int'(trip_cnt), int'(e.trip));
    if (t == 0) en_mask = '0;
    else if (t > 0 && t < 32 && cnt_en) en_mask[t] = 1'b1;
    if (m_id == 1 && t == 1) begin
      chk("basic_set", t, int'(cnt_set), 1);
      chk("basic_setval", t, int'(cnt_set_val), 2);
    end
    if (m_id == 1 && t == 9) begin
      chk("basic_pulses", t, int'(en_mask), 32'h1F8);
      chk("basic_done", t, int'(done), 1);
      chk("basic_busy", t, int'(busy), 0);
      chk("basic_final", t, int'(cval), 2);
      chk("basic_model", t, int'(e.done), 1);
    end
    if (m_id == 2 && t == 19) begin
      chk("presc_pulses", t, int'(en_mask), 32'h44440);
      chk("presc_done", t, int'(done), 1);
      chk("presc_trips", t, int'(trip_cnt), 2);
      chk("presc_final", t, int'(cval), 0);
    end
    if (m_id == 3 && t == 1) begin
      chk("cfg_err_pulse", t, int'(cfg_err), 1);
      chk("cfg_busy", t, int'(busy), 0);
      chk("cfg_set", t, int'(cnt_set), 0);
    end
    if (m_id == 4 && t == 11) begin
      chk("abort_pulse", t, int'(aborted), 1);
      chk("abort_busy", t, int'(busy), 0);
      chk("abort_en", t, int'(cnt_en), 0);
    end
    if (m_id == 5 && t == 1) begin
      chk("collide_busy", t, int'(busy), 0);
      chk("collide_set", t, int'(cnt_set), 0);
    end
    if (m_id == 6 && t == 15) chk("restart_done", t, int'(done), 1);
    if (m_id == 7 && !rst_n) begin
      chk("rst_busy", t, int'(busy), 0);
      chk("rst_en", t, int'(cnt_en), 0);
      chk("rst_trip", t, int'(trip_cnt), 0);
    end
    if (m_id == 8 && t == 7) begin
      chk("post_rst_pulses", t, int'(en_mask), 32'h78);
      chk("post_rst_done", t, int'(done), 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic do_start(int id, int l, int h, int sd, int tr, int ta);
    tick();
    m_trip_prev = model(cyc - m_s).trip;
    m_id = id;
    m_lo = l;
    m_hi = h;
    m_sd = sd;
    m_trips = tr;
    m_ta = ta;
    m_kind = (l < h) ? 1 : 2;
    m_s = cyc;
    start = 1'b1;
    lo = 4'(l);
    hi = 4'(h);
    step_div = 8'(sd);
    trips = 4'(tr);
    tick();
    start = 1'b0;
    lo = 4'(h);
    hi = 4'(l);
    step_div = 8'(sd + 5);
    trips = 4'(tr + 3);
  endtask

  initial begin
    run(3);
    rst_n = 1'b1;
    run(2);

    do_start(1, 2, 5, 0, 1, -1);
    run(12);

    do_start(2, 0, 1, 3, 2, -1);
    run(22);

    do_start(3, 7, 7, 0, 1, -1);
    run(4);
    do_start(0, 9, 3, 2, 1, -1);
    run(4);

    do_start(4, 0, 15, 0, 0, 10);
    while (cyc - m_s < 10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    run(5);

    tick();
    m_trip_prev = model(cyc - m_s).trip;
    m_id = 5;
    m_kind = 0;
    m_s = cyc;
    start = 1'b1;
    abort = 1'b1;
    lo = 4'd0;
    hi = 4'd5;
    tick();
    start = 1'b0;
    abort = 1'b0;
    run(4);

    do_start(6, 3, 6, 1, 1, -1);
    while (cyc - m_s < 5) tick();
    start = 1'b1;
    lo = 4'd0;
    hi = 4'd9;
    tick();
    start = 1'b0;
    run(14);

    do_start(0, 1, 4, 0, 0, -1);
    while (cyc - m_s < 7) tick();
    rst_n = 1'b0;
    m_id = 7;
    m_kind = 0;
    m_trip_prev = '0;
    run(2);
    rst_n = 1'b1;
    run(1);

    do_start(8, 0, 2, 0, 1, -1);
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
